// File: rtl/pipe_pkg.sv
// Shared types and constants for the LC-3b pipeline stage registers.
// Enum ordinals double as entry counts, so the state register can drive occupancy directly.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  localparam int PIPE_WIDTH = 16;

  // BR with no condition bits set never branches, so all-zero is a safe bubble.
  localparam logic [PIPE_WIDTH-1:0] LC3B_NOP = 16'h0000;

endpackage

// File: rtl/pipe_entry_reg.sv
// One payload register of the skid stage: loads only when told to, resets to the NOP word.
module pipe_entry_reg #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= NOP_VALUE;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid-buffer pipeline register with valid/ready on both sides and synchronous flush.
// in_ready comes from a flop so downstream backpressure never ripples combinationally upstream.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = PIPE_WIDTH,
  parameter logic [WIDTH-1:0] NOP_VALUE = WIDTH'(LC3B_NOP)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  skid_state_t      state_q;
  skid_state_t      state_d;
  logic             in_ready_q;
  logic             in_ready_d;
  logic             push;
  logic             pop;
  logic             head_load;
  logic             skid_load;
  logic [WIDTH-1:0] head_d;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] skid_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Flush wins over everything; the head is refilled from the skid so order stays FIFO.
  always_comb begin
    state_d   = state_q;
    head_load = 1'b0;
    skid_load = 1'b0;
    head_d    = in_data;
    push      = in_valid & in_ready_q;
    pop       = (state_q != EMPTY) & out_ready;

    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (push) begin
            state_d   = HALF;
            head_load = 1'b1;
          end
        end
        HALF: begin
          if (push && pop) begin
            head_load = 1'b1;
          end else if (push) begin
            state_d   = FULL;
            skid_load = 1'b1;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_d   = HALF;
            head_load = 1'b1;
            head_d    = skid_q;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end

    in_ready_d = (state_d != FULL);
  end

  pipe_entry_reg #(
    .WIDTH    (WIDTH),
    .NOP_VALUE(NOP_VALUE)
  ) u_head (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (head_load),
    .d      (head_d),
    .q      (head_q)
  );

  pipe_entry_reg #(
    .WIDTH    (WIDTH),
    .NOP_VALUE(NOP_VALUE)
  ) u_skid (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (skid_load),
    .d      (in_data),
    .q      (skid_q)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = (state_q == EMPTY) ? NOP_VALUE : head_q;
  assign occupancy = state_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Randomised and directed bench for pipe_skid_stage at 16 and 32 bits against a queue-based FIFO model.
module tb_pipe_skid_stage;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] in_data16;
  logic [31:0] in_data32;

  logic        in_ready16,  out_valid16;
  logic [15:0] out_data16;
  logic [1:0]  occupancy16;
  logic        in_ready32,  out_valid32;
  logic [31:0] out_data32;
  logic [1:0]  occupancy32;

  // Behavioural model: each stage is a FIFO of capacity two.
  logic [15:0] q16[$];
  logic [31:0] q32[$];
  bit          last_push;
  bit          last_flush;
  bit          check_en;

  int vec_count;
  int fail_count;

  pipe_skid_stage u_dut16 (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready16),
    .in_data  (in_data16),
    .out_valid(out_valid16),
    .out_ready(out_ready),
    .out_data (out_data16),
    .occupancy(occupancy16)
  );

  pipe_skid_stage #(
    .WIDTH    (32),
    .NOP_VALUE(32'hFFFF_0000)
  ) u_dut32 (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready32),
    .in_data  (in_data32),
    .out_valid(out_valid32),
    .out_ready(out_ready),
    .out_data (out_data32),
    .occupancy(occupancy32)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vec_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  task automatic modelReset();
    q16.delete();
    q32.delete();
    last_push  = 1'b0;
    last_flush = 1'b1;
  endtask

  // Advance the model by one clock edge using the inputs the DUT sees on that edge.
  task automatic modelStep();
    bit can_take;
    bit has_word;
    can_take   = (q16.size() < 2);
    has_word   = (q16.size() > 0);
    last_flush = flush;
    last_push  = 1'b0;
    if (flush) begin
      q16.delete();
      q32.delete();
    end else begin
      if (has_word && out_ready) begin
        void'(q16.pop_front());
        void'(q32.pop_front());
      end
      if (in_valid && can_take) begin
        q16.push_back(in_data16);
        q32.push_back(in_data32);
        last_push = 1'b1;
      end
    end
  endtask

  task automatic applyStimulus(input bit fl, input bit iv, input logic [15:0] d16,
                               input logic [31:0] d32, input bit ordy);
    flush     = fl;
    in_valid  = iv;
    in_data16 = d16;
    in_data32 = d32;
    out_ready = ordy;
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic checkLiteral16(input string tag, input bit v, input logic [15:0] d,
                                input bit rdy, input logic [1:0] occ);
    checkOutput({tag, " out_valid"}, 64'(out_valid16), 64'(v));
    checkOutput({tag, " out_data"},  64'(out_data16),  64'(d));
    checkOutput({tag, " in_ready"},  64'(in_ready16),  64'(rdy));
    checkOutput({tag, " occupancy"}, 64'(occupancy16), 64'(occ));
  endtask

  task automatic asyncResetPulse();
    #2 reset_n = 1'b0;
    modelReset();
    #1;
    checkLiteral16("async reset", 1'b0, 16'h0000, 1'b1, 2'd0);
    checkOutput("async reset out_data32", 64'(out_data32), 64'h0000_0000_FFFF_0000);
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // One compare process: DUT outputs against the FIFO model every falling edge.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("out_valid16", 64'(out_valid16), 64'(q16.size() > 0));
      checkOutput("out_data16",  64'(out_data16),  64'((q16.size() > 0) ? q16[0] : 16'h0000));
      checkOutput("in_ready16",  64'(in_ready16),  64'(q16.size() < 2));
      checkOutput("occupancy16", 64'(occupancy16), 64'(q16.size()));
      checkOutput("out_valid32", 64'(out_valid32), 64'(q32.size() > 0));
      checkOutput("out_data32",  64'(out_data32),  64'((q32.size() > 0) ? q32[0] : 32'hFFFF_0000));
      checkOutput("in_ready32",  64'(in_ready32),  64'(q32.size() < 2));
      checkOutput("occupancy32", 64'(occupancy32), 64'(q32.size()));
    end
  end

  initial begin
    bit          fl, iv, ordy;
    logic [15:0] d16;
    logic [31:0] d32;

    vec_count  = 0;
    fail_count = 0;
    check_en   = 1'b0;
    flush      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    in_data16  = '0;
    in_data32  = '0;
    modelReset();
    reset_n    = 1'b1;
    #2 reset_n = 1'b0;
    #1 check_en = 1'b1;
    checkLiteral16("reset", 1'b0, 16'h0000, 1'b1, 2'd0);
    checkOutput("reset out_data32", 64'(out_data32), 64'h0000_0000_FFFF_0000);
    @(posedge clk);
    #1 reset_n = 1'b1;

    $display("[TB] streaming");
    applyStimulus(0, 1, 16'h1111, 32'h1111_0001, 1);
    checkLiteral16("stream 1", 1'b1, 16'h1111, 1'b1, 2'd1);
    checkOutput("stream 1 out_data32", 64'(out_data32), 64'h1111_0001);
    applyStimulus(0, 1, 16'h2222, 32'h2222_0002, 1);
    checkLiteral16("stream 2", 1'b1, 16'h2222, 1'b1, 2'd1);
    checkOutput("stream 2 out_data32", 64'(out_data32), 64'h2222_0002);
    applyStimulus(0, 1, 16'h3333, 32'h3333_0003, 1);
    checkLiteral16("stream 3", 1'b1, 16'h3333, 1'b1, 2'd1);
    checkOutput("stream 3 out_data32", 64'(out_data32), 64'h3333_0003);
    applyStimulus(0, 0, 16'h0000, 32'h0, 1);
    checkLiteral16("stream drain", 1'b0, 16'h0000, 1'b1, 2'd0);
    checkOutput("stream drain out_data32", 64'(out_data32), 64'hFFFF_0000);

    $display("[TB] backpressure");
    applyStimulus(0, 1, 16'hAAAA, 32'hAAAA_AAAA, 0);
    applyStimulus(0, 1, 16'hBBBB, 32'hBBBB_BBBB, 0);
    checkLiteral16("bp full", 1'b1, 16'hAAAA, 1'b0, 2'd2);
    applyStimulus(0, 1, 16'hCCCC, 32'hCCCC_CCCC, 0);
    checkLiteral16("bp held off", 1'b1, 16'hAAAA, 1'b0, 2'd2);
    applyStimulus(0, 1, 16'hCCCC, 32'hCCCC_CCCC, 1);
    checkLiteral16("bp pop 1", 1'b1, 16'hBBBB, 1'b1, 2'd1);
    applyStimulus(0, 1, 16'hCCCC, 32'hCCCC_CCCC, 1);
    checkLiteral16("bp pop 2", 1'b1, 16'hCCCC, 1'b1, 2'd1);
    applyStimulus(0, 0, 16'h0000, 32'h0, 1);
    checkLiteral16("bp drained", 1'b0, 16'h0000, 1'b1, 2'd0);

    $display("[TB] flush with push");
    applyStimulus(0, 1, 16'h0101, 32'h0101_0101, 0);
    applyStimulus(0, 1, 16'h0202, 32'h0202_0202, 0);
    applyStimulus(1, 1, 16'hDEAD, 32'hDEAD_DEAD, 0);
    checkLiteral16("flush", 1'b0, 16'h0000, 1'b1, 2'd0);
    checkOutput("flush out_data32", 64'(out_data32), 64'hFFFF_0000);
    applyStimulus(0, 0, 16'h0000, 32'h0, 1);
    checkLiteral16("after flush", 1'b0, 16'h0000, 1'b1, 2'd0);

    $display("[TB] push and pop in HALF");
    applyStimulus(0, 1, 16'h0001, 32'h0000_0001, 0);
    applyStimulus(0, 1, 16'h0002, 32'h0000_0002, 1);
    checkLiteral16("half push pop", 1'b1, 16'h0002, 1'b1, 2'd1);
    applyStimulus(0, 0, 16'h0000, 32'h0, 1);

    $display("[TB] async reset while FULL");
    applyStimulus(0, 1, 16'h5A5A, 32'h5A5A_5A5A, 0);
    applyStimulus(0, 1, 16'hA5A5, 32'hA5A5_A5A5, 0);
    checkLiteral16("pre reset full", 1'b1, 16'h5A5A, 1'b0, 2'd2);
    asyncResetPulse();

    $display("[TB] random traffic");
    iv  = 1'b0;
    d16 = '0;
    d32 = '0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        asyncResetPulse();
      end
      if (!(iv && !last_push && !last_flush)) begin
        iv  = ($urandom_range(0, 3) != 0);
        d16 = 16'($urandom);
        d32 = $urandom;
      end
      fl   = ($urandom_range(0, 31) == 0);
      ordy = ($urandom_range(0, 2) != 0);
      applyStimulus(fl, iv, d16, d32, ordy);
    end

    applyStimulus(0, 0, 16'h0000, 32'h0, 1);
    applyStimulus(0, 0, 16'h0000, 32'h0, 1);
    applyStimulus(0, 0, 16'h0000, 32'h0, 1);
    checkLiteral16("final drain", 1'b0, 16'h0000, 1'b1, 2'd0);
    @(negedge clk);
    #1 check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, fail_count);
    $finish;
  end

endmodule
